// File: rtl/seg7_pkg.sv
// Shared segment patterns, digit index type and anode helper for the
// seven-segment scan driver.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    SYM_DIGIT,
    SYM_E,
    SYM_O,
    SYM_BLANK
  } sym_kind_e;

  // Active-high gfedcba patterns
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_O     = 7'h5C;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [3:0] an_onehot_n(input digit_idx_t idx);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << idx;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/bin_to_seg7.sv
// Combinational decimal digit / mode letter to active-high segment pattern.
module bin_to_seg7
  import seg7_pkg::*;
(
  input  sym_kind_e  kind,
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    unique case (kind)
      SYM_E:     pattern = SEG_E;
      SYM_O:     pattern = SEG_O;
      SYM_BLANK: pattern = SEG_BLANK;
      SYM_DIGIT: begin
        case (nibble)
          4'd0:    pattern = SEG_0;
          4'd1:    pattern = SEG_1;
          4'd2:    pattern = SEG_2;
          4'd3:    pattern = SEG_3;
          4'd4:    pattern = SEG_4;
          4'd5:    pattern = SEG_5;
          4'd6:    pattern = SEG_6;
          4'd7:    pattern = SEG_7;
          4'd8:    pattern = SEG_8;
          4'd9:    pattern = SEG_9;
          default: pattern = SEG_BLANK;
        endcase
      end
      default:   pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed display of the odd/even counter: mode letter,
// blank, and a two-digit decimal value with leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] q_in,
  input  logic       mode_in,
  input  logic       blank_in,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [3:0] an_n
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = $clog2(BLANK_CYC + 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_START = BLK_W'(BLANK_CYC);

  logic [3:0]       q_s1_q, q_s1_d, q_s2_q, q_s2_d, q_prev_q, q_prev_d;
  logic             m_s1_q, m_s1_d, m_s2_q, m_s2_d, m_prev_q, m_prev_d;
  logic [3:0]       val_q, val_d;
  logic             mode_q, mode_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  digit_idx_t       idx_q, idx_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic             tens;
  logic [3:0]       ones;
  sym_kind_e        kind;
  logic [3:0]       nibble;
  logic [6:0]       pattern;

  bin_to_seg7 u_bin_to_seg7 (
    .kind    (kind),
    .nibble  (nibble),
    .pattern (pattern)
  );

  always_comb begin
    q_s1_d   = q_in;
    q_s2_d   = q_s1_q;
    q_prev_d = q_s2_q;
    m_s1_d   = mode_in;
    m_s2_d   = m_s1_q;
    m_prev_d = m_s2_q;

    // Only a synchronized value seen on two consecutive cycles is accepted
    val_d  = (q_s2_q == q_prev_q) ? q_s2_q : val_q;
    mode_d = (m_s2_q == m_prev_q) ? m_s2_q : mode_q;

    tens = (val_q >= 4'd10);
    ones = tens ? (val_q - 4'd10) : val_q;

    kind   = SYM_BLANK;
    nibble = '0;
    unique case (idx_q)
      2'd0: begin
        kind   = SYM_DIGIT;
        nibble = ones;
      end
      2'd1: begin
        kind   = tens ? SYM_DIGIT : SYM_BLANK;
        nibble = 4'd1;
      end
      2'd2: kind = SYM_BLANK;
      2'd3: kind = mode_q ? SYM_O : SYM_E;
      default: kind = SYM_BLANK;
    endcase

    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    blk_d = (blk_q != '0) ? blk_q - 1'b1 : blk_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
      blk_d = BLK_START;
    end

    seg_d = ~pattern;
    an_d  = ((blk_q == '0) && !blank_in) ? an_onehot_n(idx_q) : '1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_s1_q   <= '0;
      q_s2_q   <= '0;
      q_prev_q <= '0;
      m_s1_q   <= 1'b0;
      m_s2_q   <= 1'b0;
      m_prev_q <= 1'b0;
      val_q    <= '0;
      mode_q   <= 1'b0;
      pre_q    <= '0;
      idx_q    <= '0;
      blk_q    <= BLK_START;
      seg_q    <= '1;
      an_q     <= '1;
    end else begin
      q_s1_q   <= q_s1_d;
      q_s2_q   <= q_s2_d;
      q_prev_q <= q_prev_d;
      m_s1_q   <= m_s1_d;
      m_s2_q   <= m_s2_d;
      m_prev_q <= m_prev_d;
      val_q    <= val_d;
      mode_q   <= mode_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      blk_q    <= blk_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;
  assign dp_n  = 1'b1;

endmodule
